// File: rtl/bus_pkg.sv
// Shared constants, named bus sources and helper functions for the bus arbiter.
package bus_pkg;

  localparam int DEFAULT_NUM_SRC = 24;
  localparam int DEFAULT_DATA_W  = 32;
  // Widest source vector the helper functions handle
  localparam int MAX_SRC         = 32;
  localparam int CNT_W           = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Named bus sources of the datapath
  typedef enum logic [4:0] {
    R0 = 5'd0,   R1 = 5'd1,   R2 = 5'd2,   R3 = 5'd3,
    R4 = 5'd4,   R5 = 5'd5,   R6 = 5'd6,   R7 = 5'd7,
    R8 = 5'd8,   R9 = 5'd9,   R10 = 5'd10, R11 = 5'd11,
    R12 = 5'd12, R13 = 5'd13, R14 = 5'd14, R15 = 5'd15,
    HI = 5'd16,  LO = 5'd17,  Z_HI = 5'd18, Z_LO = 5'd19,
    PC = 5'd20,  MDR = 5'd21, INPORT = 5'd22, C_SIGN_EXT = 5'd23
  } srcId_e;

  // Select width for n sources, never below one bit
  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set bit, 0 when no bit is set
  function automatic int lowestSet(input logic [MAX_SRC-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arb_mux_if.sv
// Request/data side and registered bus side of the arbitrated bus mux.
interface bus_arb_mux_if
  import bus_pkg::*;
#(
  parameter int NUM_SRC = DEFAULT_NUM_SRC,
  parameter int DATA_W  = DEFAULT_DATA_W
);

  localparam int SEL_W = selWidth(NUM_SRC);

  logic [NUM_SRC-1:0]        src_en;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      cnt_clr;
  logic [DATA_W-1:0]         bus_out;
  logic                      bus_valid;
  logic [SEL_W-1:0]          bus_sel;
  logic                      conflict;
  logic [CNT_W-1:0]          conflict_cnt;

  // Side that raises requests and observes the bus
  modport master (
    output src_en, src_data, cnt_clr,
    input  bus_out, bus_valid, bus_sel, conflict, conflict_cnt
  );

  // Arbiter side
  modport slave (
    input  src_en, src_data, cnt_clr,
    output bus_out, bus_valid, bus_sel, conflict, conflict_cnt
  );

endinterface

// File: rtl/bus_grant_encoder.sv
// Combinational grant encoder: fixed lowest-index priority, or round-robin
// searching upward from ptr+1 with wrap to 0.
module bus_grant_encoder
  import bus_pkg::*;
#(
  parameter int NUM_SRC = DEFAULT_NUM_SRC,
  parameter int RR_MODE = 0,
  parameter int SEL_W   = selWidth(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   grantIdx,
  output logic               anyGrant
);

  // Sources strictly above ptr get first look in round-robin; in fixed mode
  // the mask is empty so the search always starts at index 0.
  logic [NUM_SRC-1:0] aboveMask;
  logic [NUM_SRC-1:0] hiReq;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gMask
      assign aboveMask[gi] = (RR_MODE != 0) && (gi > int'(ptr));
    end
  endgenerate

  assign hiReq = req & aboveMask;

  // Lowest requester above ptr if any, otherwise wrap to lowest requester overall
  always_comb begin
    grantIdx = '0;
    anyGrant = |req;
    if (|hiReq) begin
      grantIdx = SEL_W'(lowestSet(MAX_SRC'(hiReq)));
    end else begin
      grantIdx = SEL_W'(lowestSet(MAX_SRC'(req)));
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered bus multiplexer: arbitrates among source drive requests, muxes
// the granted source onto the bus one cycle later and counts conflict cycles.
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter int NUM_SRC    = DEFAULT_NUM_SRC,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int RR_MODE    = 0,
  parameter int HOLD_EMPTY = 1
) (
  input  logic          clock,
  input  logic          clear_n,
  bus_arb_mux_if.slave  busIf
);

  localparam int SEL_W = selWidth(NUM_SRC);

  logic [DATA_W-1:0] busOutReg, busOutNext;
  logic              busValidReg, busValidNext;
  logic [SEL_W-1:0]  busSelReg, busSelNext;
  logic [SEL_W-1:0]  ptrReg, ptrNext;
  logic              conflictReg, conflictNext;
  logic [CNT_W-1:0]  cntReg, cntNext;

  logic [SEL_W-1:0]  grantIdx;
  logic              anyGrant;
  logic              multiReq;
  logic [DATA_W-1:0] grantData;
  logic [DATA_W-1:0] srcWord [NUM_SRC];

  // Unflatten the source data bus into one word per source
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gSrc
      assign srcWord[gi] = busIf.src_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  bus_grant_encoder #(
    .NUM_SRC (NUM_SRC),
    .RR_MODE (RR_MODE),
    .SEL_W   (SEL_W)
  ) uEncoder (
    .req      (busIf.src_en),
    .ptr      (ptrReg),
    .grantIdx (grantIdx),
    .anyGrant (anyGrant)
  );

  // Two or more requests: clearing the lowest set bit still leaves one behind
  assign multiReq = |(busIf.src_en & (busIf.src_en - NUM_SRC'(1)));

  // Select the granted word with constant indices only
  always_comb begin
    grantData = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grantIdx == SEL_W'(i)) grantData = srcWord[i];
    end
  end

  // Next bus state, pointer and saturating conflict count
  always_comb begin
    busOutNext   = busOutReg;
    busValidNext = 1'b0;
    busSelNext   = busSelReg;
    ptrNext      = ptrReg;
    conflictNext = multiReq;
    cntNext      = cntReg;
    if (anyGrant) begin
      busOutNext   = grantData;
      busValidNext = 1'b1;
      busSelNext   = grantIdx;
      ptrNext      = grantIdx;
    end else if (HOLD_EMPTY == 0) begin
      busOutNext = '0;
    end
    if (busIf.cnt_clr) begin
      cntNext = '0;
    end else if (multiReq && (cntReg != CNT_MAX)) begin
      cntNext = cntReg + CNT_W'(1);
    end
  end

  // State registers; reset parks ptr on the last source so source 0 wins first
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      busOutReg   <= '0;
      busValidReg <= 1'b0;
      busSelReg   <= '0;
      ptrReg      <= SEL_W'(NUM_SRC - 1);
      conflictReg <= 1'b0;
      cntReg      <= '0;
    end else begin
      busOutReg   <= busOutNext;
      busValidReg <= busValidNext;
      busSelReg   <= busSelNext;
      ptrReg      <= ptrNext;
      conflictReg <= conflictNext;
      cntReg      <= cntNext;
    end
  end

  assign busIf.bus_out      = busOutReg;
  assign busIf.bus_valid    = busValidReg;
  assign busIf.bus_sel      = busSelReg;
  assign busIf.conflict     = conflictReg;
  assign busIf.conflict_cnt = cntReg;

endmodule
